fb_port_arbiter: RTL and testbench

//  Shares one single-port framebuffer RAM (160x144 x 2bpp, 23040 words) between the VGA scan-out reader and the

---
 rtl/gbvga_pkg.sv | 18 +
 rtl/fb_write_fifo.sv | 72 +++++++
 rtl/fb_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gbvga_pkg.sv
// rtl/gbvga_pkg.sv - shared framebuffer types and grant encoding
package gbvga_pkg;

    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 2;
    localparam int FB_WORDS = 23040;

    typedef logic [ADDR_W-1:0] fb_addr_t;
    typedef logic [DATA_W-1:0] pix_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE,
        GNT_FORCE
    } grant_e;

endpackage

// File: rtl/fb_write_fifo.sv
// rtl/fb_write_fifo.sv - capture write queue of {addr,data} entries
module fb_write_fifo #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W+DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]           count_q, count_d;
    logic                     do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign {head_addr, head_data} = mem_q[rd_ptr_q];

    // Pointer/count update; a push into a full queue is legal only alongside a pop.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {push_addr, push_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue control state; reset discards every queued entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - display-read / capture-write arbiter for the framebuffer RAM
module fb_port_arbiter #(
    parameter int ADDR_W       = gbvga_pkg::ADDR_W,
    parameter int DATA_W       = gbvga_pkg::DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_stale,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    import gbvga_pkg::*;

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // One return-pipeline stage: read qualifiers plus the cache update the RAM op implies.
    typedef struct packed {
        logic              valid;
        logic              stale;
        logic              fill;
        logic              upd;
        logic [DATA_W-1:0] wdata;
    } stage_t;

    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
    logic                cache_valid_q, cache_valid_d;
    logic [DATA_W-1:0]   cache_data_q, cache_data_d;
    stage_t              stg1_q, stg1_d, stg2_q, stg2_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_stale_q, rd_stale_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                overflow_q, overflow_d;

    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;
    logic                fifo_full, fifo_empty;
    logic                rd_hit, rd_miss, pop, push, drop;
    grant_e              grant;

    fb_write_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Grant selection, RAM command, cache tracking, return pipeline, starve and overflow.
    always_comb begin
        rd_hit  = rd_req && cache_valid_q && (rd_addr == cache_addr_q);
        rd_miss = rd_req && !rd_hit;

        grant = GNT_IDLE;
        if ((starve_q == STARVE_MAX) && !fifo_empty) begin
            grant = GNT_FORCE;
        end else if (rd_miss) begin
            grant = GNT_READ;
        end else if (!fifo_empty) begin
            grant = GNT_WRITE;
        end

        pop  = (grant == GNT_WRITE) || (grant == GNT_FORCE);
        push = wr_req && (!fifo_full || pop);
        drop = wr_req && fifo_full && !pop;

        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;
        cache_addr_d  = cache_addr_q;
        cache_valid_d = cache_valid_q;
        if (grant == GNT_READ) begin
            ram_addr_d    = rd_addr;
            cache_addr_d  = rd_addr;
            cache_valid_d = 1'b1;
        end else if (pop) begin
            ram_addr_d  = head_addr;
            ram_we_d    = 1'b1;
            ram_wdata_d = head_data;
        end

        // Cache updates ride the pipeline so they land in RAM-op order: the later op wins.
        stg1_d.valid = rd_req;
        stg1_d.stale = rd_miss && (grant == GNT_FORCE);
        stg1_d.fill  = (grant == GNT_READ);
        stg1_d.upd   = pop && cache_valid_q && (head_addr == cache_addr_q);
        stg1_d.wdata = head_data;
        stg2_d       = stg1_q;

        rd_valid_d = stg2_q.valid;
        rd_stale_d = stg2_q.valid && stg2_q.stale;
        rd_data_d  = rd_data_q;
        if (stg2_q.valid) begin
            rd_data_d = stg2_q.fill ? ram_rdata : cache_data_q;
        end

        cache_data_d = cache_data_q;
        if (stg2_q.fill) begin
            cache_data_d = ram_rdata;
        end else if (stg2_q.upd) begin
            cache_data_d = stg2_q.wdata;
        end

        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // State registers; reset abandons in-flight reads and leaves the RAM untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            cache_addr_q  <= '0;
            cache_valid_q <= 1'b0;
            cache_data_q  <= '0;
            stg1_q        <= '0;
            stg2_q        <= '0;
            rd_valid_q    <= 1'b0;
            rd_stale_q    <= 1'b0;
            rd_data_q     <= '0;
            starve_q      <= '0;
            overflow_q    <= 1'b0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
            cache_addr_q  <= cache_addr_d;
            cache_valid_q <= cache_valid_d;
            cache_data_q  <= cache_data_d;
            stg1_q        <= stg1_d;
            stg2_q        <= stg2_d;
            rd_valid_q    <= rd_valid_d;
            rd_stale_q    <= rd_stale_d;
            rd_data_q     <= rd_data_d;
            starve_q      <= starve_d;
            overflow_q    <= overflow_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_stale  = rd_stale_q;
    assign rd_data   = rd_data_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - directed self-checking bench for fb_port_arbiter
module tb_fb_port_arbiter;
    import gbvga_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_stale;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ovf_clr;
    logic              overflow;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    fb_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_stale  (rd_stale),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Framebuffer RAM model: registered read, preloaded with mem[i] = 3 - (i % 4).
    pix_t mem [FB_WORDS];
    logic mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < FB_WORDS; i++) mem[i] <= pix_t'(3 - (i % 4));
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_stale", rd_stale, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_we", ram_we, 0);
            chk("idle_valid", rd_valid, 0);
            chk("idle_ovf", overflow, 0);
        end

        // Scan-out 0,0,1,1,2,2 with one queued write (addr 200 <= 1).
        begin : t_scan
            int req [9]  = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
            int adr [9]  = '{0, 0, 1, 1, 2, 2, 0, 0, 0};
            int ewe [9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
            int eadr [9] = '{0, 200, 1, 1, 2, 2, 2, 2, 2};
            int evld [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
            int edat [9] = '{0, 0, 3, 3, 2, 2, 1, 1, 0};
            for (int k = 0; k < 9; k++) begin
                rd_req = (req[k] != 0); rd_addr = ADDR_W'(adr[k]);
                wr_req = (k == 0); wr_addr = ADDR_W'(200); wr_data = DATA_W'(1);
                tick();
                chk("scan_we", ram_we, ewe[k]);
                chk("scan_addr", ram_addr, eadr[k]);
                chk("scan_valid", rd_valid, evld[k]);
                if (evld[k] != 0) chk("scan_data", rd_data, edat[k]);
                if (ewe[k] != 0) chk("scan_wdata", ram_wdata, 1);
            end
            chk("scan_mem200", mem[200], 1);
        end

        // Starvation: misses 0..15, one write (100 <= 2) forced on cycle 9.
        for (int k = 0; k < 18; k++) begin
            rd_req = (k < 16); rd_addr = ADDR_W'(k);
            wr_req = (k == 0); wr_addr = ADDR_W'(100); wr_data = DATA_W'(2);
            tick();
            chk("starve_we", ram_we, (k == 9) ? 1 : 0);
            if (k == 9) chk("starve_addr", ram_addr, 100);
            if (k >= 2) begin
                chk("starve_valid", rd_valid, 1);
                chk("starve_stale", rd_stale, (k == 11) ? 1 : 0);
                chk("starve_data", rd_data, (k == 11) ? 3 : 3 - ((k - 2) % 4));
            end
        end
        chk("starve_mem100", mem[100], 2);

        // Overflow: 5 writes under misses, clear, set+clear together, then drain.
        for (int k = 0; k < 13; k++) begin
            rd_req = (k < 8); rd_addr = ADDR_W'(1000 + k);
            wr_req = (k < 5) || (k == 6); wr_addr = ADDR_W'(300 + k); wr_data = DATA_W'(k % 4);
            ovf_clr = (k >= 5) && (k <= 7);
            tick();
            chk("ovf_flag", overflow, ((k == 4) || (k == 6)) ? 1 : 0);
            chk("ovf_we", ram_we, ((k >= 8) && (k <= 11)) ? 1 : 0);
            if ((k >= 8) && (k <= 11)) chk("ovf_drain_addr", ram_addr, 300 + k - 8);
        end
        wr_req = 1'b0; ovf_clr = 1'b0;
        chk("ovf_mem302", mem[302], 2);
        chk("ovf_mem303", mem[303], 3);
        chk("ovf_mem304_dropped", mem[304], 3);
        chk("ovf_mem306_dropped", mem[306], 1);

        // Coherency: miss on 50, write 50 <= 3, later hit returns 3 with no RAM op.
        for (int k = 0; k < 8; k++) begin
            rd_req = (k == 0) || (k == 5); rd_addr = ADDR_W'(50);
            wr_req = (k == 1); wr_addr = ADDR_W'(50); wr_data = DATA_W'(3);
            tick();
            if (k == 0) chk("coh_miss_addr", ram_addr, 50);
            if (k == 2) begin
                chk("coh_write_we", ram_we, 1);
                chk("coh_write_data", ram_wdata, 3);
                chk("coh_fill_data", rd_data, 1);
            end
            if ((k == 5) || (k == 6)) chk("coh_hit_no_ram", ram_we, 0);
            if (k == 7) begin
                chk("coh_hit_valid", rd_valid, 1);
                chk("coh_hit_data", rd_data, 3);
            end
        end
        chk("coh_mem50", mem[50], 3);

        // Reset mid-operation: 3 queued writes, reads in flight.
        for (int k = 0; k < 4; k++) begin
            rd_req = 1'b1; rd_addr = ADDR_W'(2000 + k);
            wr_req = (k < 3); wr_addr = ADDR_W'(400 + k); wr_data = DATA_W'(0);
            tick();
        end
        chk("mid_valid_before", rd_valid, 1);
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        #1;
        chk("mid_valid_now", rd_valid, 0);
        chk("mid_we_now", ram_we, 0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_no_write", ram_we, 0);
            chk("mid_no_valid", rd_valid, 0);
        end
        chk("mid_mem400", mem[400], 3);
        chk("mid_mem401", mem[401], 2);
        chk("mid_mem402", mem[402], 1);
        rd_req = 1'b1; rd_addr = ADDR_W'(2003);
        tick();
        chk("mid_cache_miss_addr", ram_addr, 2003);
        rd_req = 1'b1; rd_addr = ADDR_W'(2001);
        tick();
        rd_req = 1'b0;
        tick();
        chk("mid_ret_valid", rd_valid, 1);
        chk("mid_ret_data0", rd_data, 0);
        tick();
        chk("mid_ret_data1", rd_data, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
